// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffers.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    // Counter width able to hold the full range 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries with flush and a registered head entry.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int              DEPTH      = 2,
    parameter logic [XLEN-1:0] EMPTY_INST = NOP_INST_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  fetch_entry_t              i_push_data,
    input  logic                      i_pop,
    input  logic                      i_flush,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output fetch_entry_t              o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    fetch_entry_t   r_head;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;

    logic           w_push;
    logic           w_pop;
    logic [PW-1:0]  w_rd_ptr_next;
    logic [CW-1:0]  w_count_next;
    logic [CW-1:0]  w_count_after_pop;

    assign w_pop             = i_pop && (r_count != '0) && !i_flush;
    assign w_push            = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_rd_ptr_next     = r_rd_ptr + PW'(w_pop);
    assign w_count_after_pop = r_count - CW'(w_pop);
    assign w_count_next      = w_count_after_pop + CW'(w_push);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // The head register already shows the entry that will be at the front next
    // cycle, bypassing the array when that entry is being written right now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_head.pc   <= '0;
            r_head.inst <= EMPTY_INST;
        end else if (i_flush) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_head.inst <= EMPTY_INST;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_count  <= w_count_next;
            if (w_count_next == '0) begin
                r_head.inst <= EMPTY_INST;
            end else if (w_count_after_pop == '0) begin
                r_head <= i_push_data;
            end else begin
                r_head <= r_mem[w_rd_ptr_next];
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/fetch_unit.sv
// PC generation, instruction-memory request issue, in-flight tracking and
// buffering of fetched instructions toward decode, with redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] NOP_INST        = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            decode_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] curr_pc,
    output logic [XLEN-1:0] fetch_inst,
    output logic            fetch_valid
);

    localparam int CW = cnt_w(MAX_OUTSTANDING);
    localparam int OW = CW + 1;

    logic [XLEN-1:0] r_pc_next;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_pcq_count;
    logic [CW-1:0]   w_ibuf_count;
    fetch_entry_t    w_pcq_head;
    fetch_entry_t    w_ibuf_head;
    fetch_entry_t    w_pcq_push_data;
    fetch_entry_t    w_ibuf_push_data;
    logic [OW-1:0]   w_occ;
    logic            w_hs;
    logic            w_keep_rsp;
    logic            w_consume;
    logic [CW-1:0]   w_inflight_next;
    logic            w_unused;

    // Occupancy counts stale in-flight requests too, so their slots stay
    // reserved until the dropped responses actually come back.
    assign w_occ           = {1'b0, r_inflight} + {1'b0, w_ibuf_count};
    assign imem_req_valid  = rst_n && !redirect_valid && (w_occ < OW'(MAX_OUTSTANDING));
    assign imem_req_addr   = r_pc_next;
    assign w_hs            = imem_req_valid && imem_req_ready;
    assign w_keep_rsp      = imem_rsp_valid && !redirect_valid && (r_drop == '0)
                             && (w_pcq_count != '0);
    assign w_consume       = fetch_valid && !decode_stall && !redirect_valid;
    assign w_inflight_next = r_inflight + CW'(w_hs) - CW'(imem_rsp_valid);

    assign w_pcq_push_data.pc    = r_pc_next;
    assign w_pcq_push_data.inst  = '0;
    assign w_ibuf_push_data.pc   = w_pcq_head.pc;
    assign w_ibuf_push_data.inst = imem_rsp_data;

    fetch_buf #(
        .DEPTH      (MAX_OUTSTANDING),
        .EMPTY_INST (NOP_INST)
    ) u_pc_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_hs),
        .i_push_data (w_pcq_push_data),
        .i_pop       (w_keep_rsp),
        .i_flush     (redirect_valid),
        .o_count     (w_pcq_count),
        .o_head      (w_pcq_head)
    );

    fetch_buf #(
        .DEPTH      (MAX_OUTSTANDING),
        .EMPTY_INST (NOP_INST)
    ) u_inst_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_keep_rsp),
        .i_push_data (w_ibuf_push_data),
        .i_pop       (w_consume),
        .i_flush     (redirect_valid),
        .o_count     (w_ibuf_count),
        .o_head      (w_ibuf_head)
    );

    // On redirect every request still outstanding after this cycle is stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_next  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (redirect_valid) begin
                r_pc_next <= {redirect_pc[XLEN-1:2], 2'b00};
                r_drop    <= w_inflight_next;
            end else begin
                if (w_hs) begin
                    r_pc_next <= r_pc_next + XLEN'(INST_BYTES);
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    assign curr_pc     = w_ibuf_head.pc;
    assign fetch_inst  = w_ibuf_head.inst;
    assign fetch_valid = (w_ibuf_count != '0);

    assign w_unused = ^{w_pcq_head.inst, redirect_pc[1:0]};

endmodule
